// File: rtl/serial_carry_skip_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-skip slice reused over NSLICE cycles,
// LSB nibble first, with valid/ready handshakes on operand and result sides.

module carry_skip_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p_s;
  logic [3:0] g_s;
  logic       c1_s;
  logic       c2_s;
  logic       c3_s;
  logic       c4_s;

  assign p_s  = a ^ b;
  assign g_s  = a & b;
  assign c1_s = g_s[0] | (p_s[0] & cin);
  assign c2_s = g_s[1] | (p_s[1] & c1_s);
  assign c3_s = g_s[2] | (p_s[2] & c2_s);
  assign c4_s = g_s[3] | (p_s[3] & c3_s);
  assign sum  = p_s ^ {c3_s, c2_s, c1_s, cin};
  // all-propagate nibble forwards cin directly instead of waiting on the ripple
  assign cout = (&p_s) ? cin : c4_s;
endmodule

module serial_carry_skip_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_width_check
    $error("serial_carry_skip_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [3:0]       slice_sum_s;
  logic             slice_cout_s;

  carry_skip_4bit u_slice (
    .a    (a_r[3:0]),
    .b    (b_r[3:0]),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // next-state decode for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_nxt_s = DONE;
        else                   state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, status flags and nibble datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_r   <= {slice_sum_s, sum_r[WIDTH-1:4]};
          a_r     <= {4'b0000, a_r[WIDTH-1:4]};
          b_r     <= {4'b0000, b_r[WIDTH-1:4]};
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) cout_r <= slice_cout_s;
        end
        default: begin
        end
      endcase
    end
  end

  // rst gates in_ready so the source never sees a handshake during reset
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
endmodule

// File: tb/tb_serial_carry_skip_adder.sv
// Directed and randomised bench for serial_carry_skip_adder (WIDTH=32, NSLICE=8).

module tb_serial_carry_skip_adder;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_carry_skip_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge, let the next posedge accept them, then scramble inputs.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~av; b = av ^ bv; cin = ~cv;
  endtask

  // Wait for out_valid; lat = posedges from the accept edge to the edge raising out_valid.
  task automatic wait_done(output int lat);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    lat = cyc - 1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] hold_sum;
    logic [WIDTH:0]   model;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum_cout", {31'd0, cout, sum}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // all-propagate: skip path in every slice
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_in_ready_run", {63'd0, in_ready}, 64'd0);
    wait_done(lat);
    chk("t1_result", {31'd0, cout, sum}, {31'd0, 1'b1, 32'h0000_0000});
    take_result();

    // mixed carries and exact latency
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_done(lat);
    chk("t2_latency", 64'(lat), 64'd8);
    chk("t2_result", {31'd0, cout, sum}, {31'd0, 1'b0, 32'hACF1_3568});
    take_result();
    chk("t2_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("t2_idle_sum_held", {31'd0, cout, sum}, {31'd0, 1'b0, 32'hACF1_3568});

    start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(lat);
    chk("t3a_result", {31'd0, cout, sum}, {31'd0, 1'b1, 32'h0000_0000});
    take_result();
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(lat);
    chk("t3b_result", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h8000_0000});

    // backpressure in DONE with ignored in_valid pulses
    hold_sum = sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 32'h1111_1111 * i; b = 32'h2222_2222;
      @(negedge clk);
      chk("t4_out_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_stable", {31'd0, cout, sum}, {31'd0, 1'b0, hold_sum});
      chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    take_result();
    @(negedge clk);
    chk("t4_not_queued", {62'd0, busy, out_valid}, 64'd0);

    // reset abort during RUN
    start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_sum", {31'd0, cout, sum}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_in_ready_rst", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_no_out_valid", {63'd0, out_valid}, 64'd0);
    start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    wait_done(lat);
    chk("t5_new_op", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h1010_1011});
    take_result();

    // random operands, input gaps and output stalls
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (k % 16 == 0) rb = ~ra;
      model = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(ra, rb, rc);
      wait_done(lat);
      chk("rand_result", {31'd0, cout, sum}, {31'd0, model});
      n = 0;
      out_ready = 1'($urandom_range(0, 1));
      while (!out_ready && n < 20) begin
        @(negedge clk);
        n++;
        out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
